// File: rtl/sram_rd_pkg.sv
// Shared definitions for the SRAM read streamer: FSM encoding and width defaults.
package sram_rd_pkg;

  localparam int ADDR_W_DEF = 19;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sram_rd_fifo.sv
// Synchronous output buffer for the SRAM read streamer; storage is not reset,
// only pointers and count are.
module sram_rd_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              do_push, do_pop;

  always_comb begin
    full     = (count_q == (PTR_W+1)'(DEPTH));
    empty    = (count_q == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + (PTR_W+1)'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - (PTR_W+1)'(1);
    end
    count = count_q;
    rdata = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/sram_rd_streamer.sv
// Streams words read from a 1-cycle-latency SRAM into a valid/ready output.
// Define SRAM_RD_2D_EN to read `lines` lines of `len` words spaced by `pitch`.
module sram_rd_streamer
  import sram_rd_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] len,
  input  logic [ADDR_W-1:0] lines,
  input  logic [ADDR_W-1:0] pitch,
  output logic              busy,
  output logic              done,
  output logic              sram_csn,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_a,
  input  logic [DATA_W-1:0] sram_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] remain_q, remain_d;
  logic              inflight_q, inflight_d;
  logic              issue, last_issue, empty_xfer, drain_empty, pop;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    occupancy;

`ifdef SRAM_RD_2D_EN
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] lines_left_q, lines_left_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [ADDR_W-1:0] pitch_q, pitch_d;
`else
  // Linear build has no line stepping; the 2D inputs are intentionally dropped.
  logic unused_2d;
  assign unused_2d = ^{lines, pitch};
`endif

  // Words already buffered plus the one in flight bound how far reads may run ahead.
  always_comb begin
    pop         = !fifo_empty && m_ready;
    occupancy   = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    issue       = (state_q == ST_RUN) && !fifo_full && (occupancy < DEPTH_C);
    drain_empty = !inflight_q && (fifo_empty || (fifo_count == CNT_W'(1) && pop));
`ifdef SRAM_RD_2D_EN
    last_issue  = (remain_q == ADDR_W'(1)) && (lines_left_q == ADDR_W'(1));
    empty_xfer  = (len == '0) || (lines == '0);
`else
    last_issue  = (remain_q == ADDR_W'(1));
    empty_xfer  = (len == '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = empty_xfer ? ST_DONE : ST_RUN;
      ST_RUN:   if (issue && last_issue) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_empty) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DONE);
    sram_csn = !issue;
    sram_wen = 1'b0;
    sram_a   = addr_q;
  end

  always_comb begin
    addr_d     = addr_q;
    remain_d   = remain_q;
    inflight_d = issue;
`ifdef SRAM_RD_2D_EN
    len_d        = len_q;
    lines_left_d = lines_left_q;
    line_base_d  = line_base_q;
    pitch_d      = pitch_q;
`endif
    if (state_q == ST_IDLE && start) begin
      addr_d   = base;
      remain_d = len;
`ifdef SRAM_RD_2D_EN
      len_d        = len;
      lines_left_d = lines;
      line_base_d  = base;
      pitch_d      = pitch;
`endif
    end else if (issue) begin
      addr_d   = addr_q + ADDR_W'(1);
      remain_d = remain_q - ADDR_W'(1);
`ifdef SRAM_RD_2D_EN
      // End of a line: jump to the next line start and reload the word count.
      if (remain_q == ADDR_W'(1)) begin
        addr_d       = line_base_q + pitch_q;
        line_base_d  = line_base_q + pitch_q;
        remain_d     = len_q;
        lines_left_d = lines_left_q - ADDR_W'(1);
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clk) begin
    remain_q <= remain_d;
`ifdef SRAM_RD_2D_EN
    len_q        <= len_d;
    lines_left_q <= lines_left_d;
    line_base_q  <= line_base_d;
    pitch_q      <= pitch_d;
`endif
  end

  sram_rd_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (inflight_q),
    .wdata (sram_dout),
    .pop   (pop),
    .rdata (m_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign m_valid = !fifo_empty;

endmodule

// File: doc/sram_rd_streamer.md
SRAM_RD_STREAMER -- requirements
Module: sram_rd_streamer

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, SRAM/stream data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output buffer depth in words (power of 2, >=2).
REQ-004 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rstn  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  in  1  one-cycle request to begin a transfer.
REQ-007 SHALL have port base  in  ADDR_W  first word address, sampled on accepted start.
REQ-008 SHALL have port len  in  ADDR_W  words per line (linear mode: total words), sampled on accepted start.
REQ-009 SHALL have port lines  in  ADDR_W  line count (2D mode only; ignored otherwise).
REQ-010 SHALL have port pitch  in  ADDR_W  address step between line starts (2D mode only; ignored otherwise).
REQ-011 SHALL have port busy  out  1  high from accepted start until done.
REQ-012 SHALL have port done  out  1  one-cycle pulse when the transfer completes.
REQ-013 SHALL have ports sram_csn, sram_wen (out, 1 each), sram_a (out, ADDR_W) and sram_dout (in, DATA_W), driving the SRAM.
REQ-014 SHALL have ports m_valid (out, 1), m_ready (in, 1) and m_data (out, DATA_W), forming the output stream.

Function
REQ-015 SHALL perform reads only: sram_wen SHALL be constant 0, because the SRAM writes when wen=1.
REQ-016 SHALL issue one read per cycle by driving sram_csn=0 with sram_a; the data SHALL be taken from sram_dout on the next cycle (1-cycle latency).
REQ-017 SHALL issue a read only if FIFO occupancy + in-flight reads < FIFO_DEPTH, so no word is ever dropped.
REQ-018 SHALL use FSM states IDLE, RUN, DRAIN, DONE: IDLE->RUN on start; RUN->DRAIN after the last read is issued; DRAIN->DONE when FIFO empty and nothing in flight; DONE->IDLE after one cycle.
REQ-019 SHALL, on start with len=0 (or lines=0 in 2D mode), go IDLE->DONE, issue no read and pulse done.
REQ-020 SHALL ignore start while busy=1.
REQ-021 SHALL compute addresses modulo 2^ADDR_W; an address past the top wraps to 0 silently.
REQ-022 SHALL transfer a stream word only when m_valid=1 and m_ready=1; m_data SHALL stay stable while m_valid=1 and m_ready=0.
REQ-023 SHALL deliver words in issue order, at up to 1 word/cycle when m_ready is held at 1.
REQ-024 SHALL assert done in the DONE-state cycle, which is exactly one cycle after the last word is accepted.

Reset
REQ-025 SHALL, on rstn=0 at a clock edge, clear these outputs: busy=0, done=0, m_valid=0, sram_csn=1, sram_a=0.
REQ-026 SHALL, on rstn=0 at a clock edge, clear the FSM to IDLE, flush the FIFO and clear the in-flight flag, aborting any transfer with no done pulse.

Configuration
REQ-027 SHALL, with SRAM_RD_2D_EN defined, read `lines` lines of `len` words each; line k SHALL start at base + k*pitch, and the last read is the last word of the last line.
REQ-028 SHALL, without SRAM_RD_2D_EN, read len consecutive words from base; lines and pitch SHALL be unused and the line counter SHALL be absent.

Structure
REQ-029 SHALL place the FSM state encoding and the ADDR_W/DATA_W defaults in shared package sram_rd_pkg.
REQ-030 SHALL implement the output buffer as sub-module sram_rd_fifo: a synchronous FIFO with full/empty flags and a count.

Verification
REQ-031 SHALL cover: base=0x00010, len=8, m_ready=1 -> addresses 0x00010..0x00017 on consecutive cycles, 8 words in order, done one cycle after the 8th.
REQ-032 SHALL cover: len=16, m_ready toggling 1/0 every cycle -> no loss or duplication, m_data stable during stalls, reads never exceed FIFO_DEPTH ahead.
REQ-033 SHALL cover: base=0x7FFFE, len=4 -> addresses 0x7FFFE, 0x7FFFF, 0x00000, 0x00001.
REQ-034 SHALL cover: len=0 -> no sram_csn=0 cycle, done pulse within 2 cycles of start; a second start while busy -> ignored.
REQ-035 SHALL cover: rstn=0 mid-transfer (after 3 of 10 words) -> next cycle busy=0, m_valid=0, sram_csn=1, no done; a new start then works normally.
REQ-036 SHALL cover, with SRAM_RD_2D_EN: base=0x100, len=3, lines=2, pitch=0x10 -> addresses 0x100-0x102 then 0x110-0x112.
